// File: rtl/chip_test_controller_pkg.sv
// chip_test_pkg: shared types and constants for the chip test controller.
//   ctl_state_t : controller state encoding (IDLE, LAUNCH, WAIT_DONE, SHOW)
//   CNT_W       : width of the saturating pass/fail counters
package chip_test_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    SHOW      = 2'd3
  } ctl_state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/chip_test_controller_if.sv
// chip_test_controller_if: handshake between the controller and the chip tester.
//   Run       : controller -> tester, start request
//   DISP_RSLT : controller -> tester, present result
//   Done      : tester -> controller, completion flag
//   RSLT      : tester -> controller, 1 = pass, valid while Done = 1
// master = controller side, slave = tester side.
interface chip_test_controller_if;
  logic Run;
  logic DISP_RSLT;
  logic Done;
  logic RSLT;

  modport master (output Run, output DISP_RSLT, input Done, input RSLT);
  modport slave  (input Run, input DISP_RSLT, output Done, output RSLT);
endinterface

// File: rtl/chip_test_controller_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, level debouncer and press-pulse generator
// for one active-low push-button.
//   Clk   : system clock
//   Reset : asynchronous active-low reset
//   btn_n : raw button, active-low, asynchronous to Clk
//   press : one-cycle pulse on the accepted high-to-low transition
// Press latency from the button going low is 2 + DEBOUNCE_CYCLES cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_n,
  output logic press
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      // synchronizer stages
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // cnt holds how many consecutive samples have disagreed with level;
      // the sample arriving with cnt == LAST is the DEBOUNCE_CYCLES-th one.
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync_p1;
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/chip_test_controller.sv
// chip_test_controller: front end for a single chip tester.
//   Clk, Reset            : clock, asynchronous active-low reset
//   Start_n, Clear_n      : raw active-low push-buttons
//   tst (master)          : Run / DISP_RSLT out, Done / RSLT in
//   Busy                  : test in progress (WAIT_DONE)
//   Pass / Fail / Timeout : outcome of the last test, held until next launch
//   pass_count/fail_count : saturating counts; a timeout counts as a fail
module chip_test_controller
  import chip_test_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Start_n,
  input  logic                          Clear_n,
  chip_test_controller_if.master        tst,
  output logic                          Busy,
  output logic                          Pass,
  output logic                          Fail,
  output logic                          Timeout,
  output logic [CNT_W-1:0]              pass_count,
  output logic [CNT_W-1:0]              fail_count
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic          start_press;
  logic          clear_press;
  ctl_state_t    state;
  ctl_state_t    state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          run;
  logic          disp;
  logic          busy;
  logic          done_exit;
  logic          tmo_exit;
  logic          launch_go;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .Clk   (Clk),
    .Reset (Reset),
    .btn_n (Start_n),
    .press (start_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .Clk   (Clk),
    .Reset (Reset),
    .btn_n (Clear_n),
    .press (clear_press)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Run/Busy/DISP_RSLT decode straight from the state register so an
  // asynchronous reset drops them immediately.
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    busy      = 1'b0;
    disp      = 1'b0;
    done_exit = 1'b0;
    tmo_exit  = 1'b0;
    case (state)
      IDLE: begin
        if (start_press) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        run       = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        run  = 1'b1;
        busy = 1'b1;
        // Done has priority over a timeout landing in the same cycle
        if (tst.Done) begin
          done_exit = 1'b1;
          state_nxt = SHOW;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_exit  = 1'b1;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        disp = 1'b1;
        if (start_press) state_nxt = LAUNCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign launch_go     = (state_nxt == LAUNCH);
  assign tst.Run       = run;
  assign tst.DISP_RSLT = disp;
  assign Busy          = busy;

  // Timeout counter is always cleared in LAUNCH before it is looked at,
  // so it needs no reset.
  always_ff @(posedge Clk) begin
    if (state == LAUNCH)         tmo_cnt <= '0;
    else if (state == WAIT_DONE) tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Pass    <= 1'b0;
      Fail    <= 1'b0;
      Timeout <= 1'b0;
    end else if (launch_go) begin
      Pass    <= 1'b0;
      Fail    <= 1'b0;
      Timeout <= 1'b0;
    end else if (done_exit) begin
      Pass    <= tst.RSLT;
      Fail    <= ~tst.RSLT;
      Timeout <= 1'b0;
    end else if (tmo_exit) begin
      Timeout <= 1'b1;
    end
  end

  // Clear has priority over an increment in the same cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (clear_press) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (done_exit && tst.RSLT) begin
      pass_count <= sat_inc(pass_count);
    end else if (done_exit || tmo_exit) begin
      fail_count <= sat_inc(fail_count);
    end
  end

endmodule

// File: tb/tb_chip_test_controller.sv
// tb_chip_test_controller: directed bench for chip_test_controller.
// dut_a uses the default timeout (long tester responses, bounce, saturation,
// clear); dut_b uses TIMEOUT_CYCLES = 50 (timeout, Done/timeout collision,
// reset during a test). Both use DEBOUNCE_CYCLES = 16, so a held button gives
// Run 19 cycles after it goes low (2 sync + 16 debounce + 1 launch).
module tb_chip_test_controller;
  import chip_test_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic start_a_n = 1'b1, clear_a_n = 1'b1;
  logic start_b_n = 1'b1, clear_b_n = 1'b1;
  logic busy_a, pass_a, fail_a, tmo_a;
  logic busy_b, pass_b, fail_b, tmo_b;
  logic [CNT_W-1:0] pcnt_a, fcnt_a, pcnt_b, fcnt_b;

  chip_test_controller_if if_a ();
  chip_test_controller_if if_b ();

  always #5 Clk = ~Clk;

  chip_test_controller #(.DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(65535)) u_dut_a (
    .Clk(Clk), .Reset(Reset), .Start_n(start_a_n), .Clear_n(clear_a_n), .tst(if_a),
    .Busy(busy_a), .Pass(pass_a), .Fail(fail_a), .Timeout(tmo_a),
    .pass_count(pcnt_a), .fail_count(fcnt_a)
  );

  chip_test_controller #(.DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(50)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .Start_n(start_b_n), .Clear_n(clear_b_n), .tst(if_b),
    .Busy(busy_b), .Pass(pass_b), .Fail(fail_b), .Timeout(tmo_b),
    .pass_count(pcnt_b), .fail_count(fcnt_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_run_a(input int limit, output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!if_a.Run && n < limit);
  endtask

  task automatic wait_run_b(input int limit, output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!if_b.Run && n < limit);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   lat;
    int   launches;
    logic prev;

    if_a.Done = 1'b0; if_a.RSLT = 1'b0;
    if_b.Done = 1'b0; if_b.RSLT = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    // Reset state
    check_eq("rst_run_a",  if_a.Run, 0);
    check_eq("rst_disp_a", if_a.DISP_RSLT, 0);
    check_eq("rst_busy_a", busy_a, 0);
    check_eq("rst_flags_a", {pass_a, fail_a, tmo_a}, 0);
    check_eq("rst_pcnt_a", pcnt_a, 0);
    check_eq("rst_fcnt_a", fcnt_a, 0);
    check_eq("rst_run_b",  if_b.Run, 0);

    // Pass after 100 cycles; a second press during WAIT_DONE must be ignored
    fork
      begin
        start_a_n = 1'b0; repeat (40) @(negedge Clk);
        start_a_n = 1'b1; repeat (20) @(negedge Clk);
        start_a_n = 1'b0; repeat (25) @(negedge Clk);
        start_a_n = 1'b1;
      end
      begin
        wait_run_a(100, lat);
        check_eq("start_latency", lat, 19);
        check_eq("launch_busy", busy_a, 0);
        @(negedge Clk);
        check_eq("wait_busy", busy_a, 1);
        repeat (99) @(negedge Clk);
        check_eq("run_held", if_a.Run, 1);
        if_a.Done = 1'b1; if_a.RSLT = 1'b1;
        @(negedge Clk);
        if_a.Done = 1'b0; if_a.RSLT = 1'b0;
        check_eq("t1_pass", pass_a, 1);
        check_eq("t1_fail", fail_a, 0);
        check_eq("t1_tmo", tmo_a, 0);
        check_eq("t1_disp", if_a.DISP_RSLT, 1);
        check_eq("t1_run", if_a.Run, 0);
        check_eq("t1_busy", busy_a, 0);
        check_eq("t1_pcnt", pcnt_a, 1);
        check_eq("t1_fcnt", fcnt_a, 0);
        repeat (20) @(negedge Clk);
        check_eq("no_queued_start", if_a.Run, 0);
        check_eq("show_held_disp", if_a.DISP_RSLT, 1);
      end
    join

    // Failing test; flags clear on entry to LAUNCH
    start_a_n = 1'b0;
    wait_run_a(100, n);
    check_eq("flags_clr_launch", {pass_a, fail_a, tmo_a}, 0);
    check_eq("launch_disp", if_a.DISP_RSLT, 0);
    repeat (4) @(negedge Clk);
    if_a.Done = 1'b1; if_a.RSLT = 1'b0;
    @(negedge Clk);
    if_a.Done = 1'b0;
    check_eq("t2_fail", fail_a, 1);
    check_eq("t2_pass", pass_a, 0);
    check_eq("t2_fcnt", fcnt_a, 1);
    check_eq("t2_pcnt", pcnt_a, 1);
    start_a_n = 1'b1;
    repeat (25) @(negedge Clk);

    // Bounce: Done held high so any extra press would show as another launch
    if_a.Done = 1'b1; if_a.RSLT = 1'b1;
    launches = 0;
    prev = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          start_a_n = (i % 2 == 0) ? 1'b0 : 1'b1;
          repeat (3) @(negedge Clk);
        end
        start_a_n = 1'b0; repeat (40) @(negedge Clk);
        start_a_n = 1'b1; repeat (30) @(negedge Clk);
      end
      begin
        repeat (100) begin
          @(negedge Clk);
          if (if_a.Run && !prev) launches++;
          prev = if_a.Run;
        end
      end
    join
    check_eq("bounce_launches", launches, 1);
    check_eq("bounce_pcnt", pcnt_a, 2);

    // 300 passing tests saturate pass_count
    for (int i = 0; i < 300; i++) begin
      start_a_n = 1'b0; repeat (24) @(negedge Clk);
      start_a_n = 1'b1; repeat (24) @(negedge Clk);
      if (i == 200) check_eq("pcnt_mid", pcnt_a, 203);
    end
    if_a.Done = 1'b0;
    check_eq("pcnt_sat", pcnt_a, 255);
    check_eq("fcnt_keep", fcnt_a, 1);
    clear_a_n = 1'b0; repeat (24) @(negedge Clk);
    clear_a_n = 1'b1;
    check_eq("clr_pcnt", pcnt_a, 0);
    check_eq("clr_fcnt", fcnt_a, 0);
    repeat (24) @(negedge Clk);

    // Timeout on dut_b: 51 cycles after Run rises
    start_b_n = 1'b0;
    wait_run_b(100, lat);
    check_eq("b_latency", lat, 19);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!tmo_b && n < 200);
    check_eq("tmo_delay", n, 51);
    check_eq("tmo_run", if_b.Run, 0);
    check_eq("tmo_disp", if_b.DISP_RSLT, 1);
    check_eq("tmo_pass", pass_b, 0);
    check_eq("tmo_fail", fail_b, 0);
    check_eq("tmo_fcnt", fcnt_b, 1);
    check_eq("tmo_pcnt", pcnt_b, 0);
    start_b_n = 1'b1;
    repeat (25) @(negedge Clk);

    // Done with RSLT=0 in the very cycle the timeout limit is reached
    start_b_n = 1'b0;
    wait_run_b(100, n);
    check_eq("tmo_clr_launch", tmo_b, 0);
    repeat (50) @(negedge Clk);
    check_eq("pre_limit_tmo", tmo_b, 0);
    check_eq("pre_limit_busy", busy_b, 1);
    if_b.Done = 1'b1; if_b.RSLT = 1'b0;
    @(negedge Clk);
    if_b.Done = 1'b0;
    check_eq("tie_fail", fail_b, 1);
    check_eq("tie_tmo", tmo_b, 0);
    check_eq("tie_pass", pass_b, 0);
    check_eq("tie_fcnt", fcnt_b, 2);
    start_b_n = 1'b1;
    repeat (25) @(negedge Clk);

    // Reset asserted during WAIT_DONE
    start_b_n = 1'b0;
    wait_run_b(100, n);
    repeat (5) @(negedge Clk);
    check_eq("pre_rst_busy", busy_b, 1);
    Reset = 1'b0;
    start_b_n = 1'b1;
    #1;
    check_eq("rst_async_run", if_b.Run, 0);
    check_eq("rst_async_busy", busy_b, 0);
    check_eq("rst_async_flags", {pass_b, fail_b, tmo_b}, 0);
    check_eq("rst_async_disp", if_b.DISP_RSLT, 0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    if_b.Done = 1'b1; if_b.RSLT = 1'b0;
    @(negedge Clk);
    if_b.Done = 1'b0;
    check_eq("post_rst_run", if_b.Run, 0);
    check_eq("post_rst_disp", if_b.DISP_RSLT, 0);
    check_eq("post_rst_fcnt", fcnt_b, 0);
    check_eq("post_rst_pcnt", pcnt_b, 0);
    check_eq("post_rst_flags", {pass_b, fail_b, tmo_b}, 0);

    // Controller restarts normally from IDLE after reset
    start_b_n = 1'b0;
    wait_run_b(100, lat);
    check_eq("idle_restart_lat", lat, 19);
    if_b.Done = 1'b1; if_b.RSLT = 1'b1;
    repeat (2) @(negedge Clk);
    if_b.Done = 1'b0;
    check_eq("restart_pass", pass_b, 1);
    check_eq("restart_pcnt", pcnt_b, 1);
    start_b_n = 1'b1;
    repeat (5) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
